// File: rtl/reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports
// with same-cycle write bypass, one synchronous write port, $zero hardwired.
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] write_data,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              write_en;
    logic              bypass1;
    logic              bypass2;

    // Effective write: reset wins, and $zero is never a target.
    assign write_en = rst_n && reg_write && (rd != ADDR_W'(0));

    // Storage array: synchronous clear, then gated writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= DATA_W'(0);
            end
        end else if (write_en) begin
            regs[rd] <= write_data;
        end
    end

    // Bypass only matches a write that will actually commit at the next edge.
    assign bypass1 = write_en && (rd == rs);
    assign bypass2 = write_en && (rd == rt);

    // Read ports: $zero first, then in-flight write, then stored contents.
    always_comb begin
        read_data1 = DATA_W'(0);
        read_data2 = DATA_W'(0);

        if (rs == ADDR_W'(0)) begin
            read_data1 = DATA_W'(0);
        end else if (bypass1) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs[rs];
        end

        if (rt == ADDR_W'(0)) begin
            read_data2 = DATA_W'(0);
        end else if (bypass2) begin
            read_data2 = write_data;
        end else begin
            read_data2 = regs[rt];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file: inputs change on the falling edge,
// reads are checked just after, and any write commits at the following rising edge.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks;
    int errors;

    reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        reg_write;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t tv [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] wa, input logic [31:0] d);
        @(negedge clk);
        rst_n      = r;
        reg_write  = w;
        rs         = a1;
        rt         = a2;
        rd         = wa;
        write_data = d;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; reg_write = 1'b0; rs = '0; rt = '0; rd = '0; write_data = '0;

        // name, rst_n, reg_write, rs, rt, rd, wdata, exp1, exp2
        tv.push_back('{"wr5_bypass",      1'b1, 1'b1, 5'd5,  5'd0,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0});
        tv.push_back('{"rd5_rd10",        1'b1, 1'b0, 5'd5,  5'd10, 5'd0,  32'h0,        32'hA5A5A5A5, 32'h0});
        tv.push_back('{"wr10_bypass",     1'b1, 1'b1, 5'd5,  5'd10, 5'd10, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tv.push_back('{"rd10_rd0",        1'b1, 1'b0, 5'd10, 5'd0,  5'd0,  32'h0,        32'h5A5A5A5A, 32'h0});
        tv.push_back('{"rd15_unwritten",  1'b1, 1'b0, 5'd15, 5'd5,  5'd0,  32'h0,        32'h0,        32'hA5A5A5A5});
        tv.push_back('{"wr15_bypass_both",1'b1, 1'b1, 5'd15, 5'd15, 5'd15, 32'h12345678, 32'h12345678, 32'h12345678});
        tv.push_back('{"rd15_rd10",       1'b1, 1'b0, 5'd15, 5'd10, 5'd0,  32'h0,        32'h12345678, 32'h5A5A5A5A});
        tv.push_back('{"rd5_same_both",   1'b1, 1'b0, 5'd5,  5'd5,  5'd0,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5});
        tv.push_back('{"wr0_during",      1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0});
        tv.push_back('{"wr0_after",       1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0});
        tv.push_back('{"we0_no_bypass",   1'b1, 1'b0, 5'd5,  5'd15, 5'd5,  32'hFFFFFFFF, 32'hA5A5A5A5, 32'h12345678});
        tv.push_back('{"we0_no_write",    1'b1, 1'b0, 5'd5,  5'd31, 5'd0,  32'h0,        32'hA5A5A5A5, 32'h0});
        tv.push_back('{"wr31_bypass",     1'b1, 1'b1, 5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0});
        tv.push_back('{"rd31_both",       1'b1, 1'b0, 5'd31, 5'd31, 5'd0,  32'h0,        32'hCAFEF00D, 32'hCAFEF00D});
        tv.push_back('{"rst_wr7_no_byp",  1'b0, 1'b1, 5'd7,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'hA5A5A5A5});
        tv.push_back('{"rd7_after_rst",   1'b1, 1'b0, 5'd7,  5'd5,  5'd0,  32'h0,        32'h0,        32'h0});
        tv.push_back('{"rd15_31_cleared", 1'b1, 1'b0, 5'd15, 5'd31, 5'd0,  32'h0,        32'h0,        32'h0});
        tv.push_back('{"rd10_cleared",    1'b1, 1'b0, 5'd10, 5'd7,  5'd0,  32'h0,        32'h0,        32'h0});

        // Reset for two edges with a write pending: bypass suppressed, nothing stored.
        drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h11111111);
        check("rst_cycle1_rd1", read_data1, 32'h0);
        drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h11111111);
        check("rst_cycle2_rd2", read_data2, 32'h0);

        // Post-reset sweep: every register reads zero on both ports.
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0);
            check($sformatf("sweep_rs%0d", a), read_data1, 32'h0);
            check($sformatf("sweep_rt%0d", 31 - a), read_data2, 32'h0);
        end

        foreach (tv[i]) begin
            drive(tv[i].rst_n, tv[i].reg_write, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].wdata);
            check({tv[i].name, "_rd1"}, read_data1, tv[i].exp1);
            check({tv[i].name, "_rd2"}, read_data2, tv[i].exp2);
        end

        // Bypass tracks write_data combinationally within one cycle.
        drive(1'b1, 1'b1, 5'd20, 5'd21, 5'd20, 32'h0000BEEF);
        check("byp_live_a", read_data1, 32'h0000BEEF);
        write_data = 32'h0BADF00D;
        #1;
        check("byp_live_b", read_data1, 32'h0BADF00D);
        check("byp_live_other", read_data2, 32'h0);
        drive(1'b1, 1'b0, 5'd20, 5'd21, 5'd0, 32'h0);
        check("byp_live_commit", read_data1, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file for the Decode stage of the five-stage MIPS pipeline. It holds 32 architectural registers of 32 bits each. It provides two asynchronous read ports, addressed by the instruction's rs and rt fields, and one synchronous write port fed by the Write-Back stage. Register 0 is hardwired to zero.

## Interface
Parameters:
- None; widths fixed at 32 registers × 32 bits, 5-bit addresses.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous and active-low, sampled on rising edge of clk.
- reg_write  input  1  write enable from Write-Back.
- rs  input  5  read address, port 1.
- rt  input  5  read address, port 2.
- rd  input  5  write address.
- write_data  input  32  data to write into register rd.
- read_data1  output  32  contents of register rs (combinational).
- read_data2  output  32  contents of register rt (combinational).

## Operation
- Storage: 32 entries × 32 bits, indices 0..31.
- Reset: on rising clk with rst_n=0, all 32 entries clear to 32'h0000_0000. Reset has priority over any write in the same cycle.
- Write: on rising clk with rst_n=1, reg_write=1 and rd≠0, entry[rd] ← write_data. When reg_write=0, no entry changes.
- Register 0: writes with rd=0 are ignored. Entry 0 always reads 32'h0 on both ports.
- Read port 1 (combinational):
  - rs=0 → 32'h0.
  - Else, if reg_write=1, rd=rs and rst_n=1 → write_data (same-cycle write bypass).
  - Else → entry[rs].
- Read port 2: identical rule using rt.
- Both ports may address the same register simultaneously; both return the same value.
- No internal read state; outputs depend only on the current addresses, the bypass inputs and the stored contents.

## Timing
- Write latency: write_data is committed at the first rising clk edge where reg_write=1. The stored value is visible through the array from that edge onward.
- Read latency: zero cycles. Outputs settle combinationally after rs, rt or stored contents change, and after any bypass input change.
- Bypass: a read of rd during the write cycle returns the new value before the edge. This lets Write-Back and Decode overlap in one cycle.
- Outputs after reset: read_data1 = read_data2 = 32'h0 for any address, until a write occurs.
- Reset mid-operation: a write pending in the reset cycle is discarded.
  - The bypass is suppressed while rst_n=0, so reads return stored (cleared) values.
- No X propagation: every register is defined after reset.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then sweep rs and rt over 0..31 → all reads 32'h0.
- Write then read:
  - reg_write=1, rd=5, write_data=32'hA5A5A5A5 for one edge.
  - Then reg_write=0, rs=5, rt=10 → read_data1=32'hA5A5A5A5, read_data2=32'h0.
- Bypass and second write:
  - reg_write=1, rd=10, write_data=32'h5A5A5A5A, rt=10 → read_data2=32'h5A5A5A5A before the edge.
  - After the edge, with reg_write=0, rs=10, rt=0 → 32'h5A5A5A5A and 32'h0.
- Unwritten, then written:
  - rs=15 → 32'h0.
  - Write rd=15, write_data=32'h12345678, then rs=15 → 32'h12345678. Registers 5 and 10 are unchanged.
- $zero protection: reg_write=1, rd=0, write_data=32'hFFFFFFFF → rs=0 and rt=0 read 32'h0, both during and after the edge.
- Reset priority: rst_n=0 with reg_write=1, rd=7, write_data=32'hDEADBEEF → after the edge, rs=7 reads 32'h0. Previously written registers also read 32'h0.
